atmega_spi_s: RTL and testbench

ATMEGA_SPI_S -- requirements
Module: atmega_spi_s

---
 rtl/atmega_spi_s.sv | 169 ++++++++++++++++
 tb/tb_atmega_spi_s.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/atmega_spi_s.sv
// SPI slave with AVR-style SPCR/SPSR/SPDR register interface.
// External pins are synchronized; slave modes 0 and 2 (CPHA=0) only.
module atmega_spi_s #(
  parameter string PLATFORM = "XILINX",
  parameter int BUS_ADDR_IO_LEN = 6,
  parameter logic [BUS_ADDR_IO_LEN-1:0] SPCR_ADDR = 0,
  parameter logic [BUS_ADDR_IO_LEN-1:0] SPSR_ADDR = 1,
  parameter logic [BUS_ADDR_IO_LEN-1:0] SPDR_ADDR = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BUS_ADDR_IO_LEN-1:0] addr,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [7:0]                 bus_in,
  output logic [7:0]                 bus_out,
  output logic                       int_o,
  input  logic                       int_rst,
  output logic                       io_connect,
  input  logic                       sck,
  input  logic                       ss_n,
  input  logic                       mosi,
  output logic                       miso,
  output logic                       miso_oe
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;

  if (PLATFORM == "") begin : g_platform_none
  end

  logic [7:0] spcr_q, spdr_rx_q, tx_buf_q, tx_shift_q, rx_shift_q;
  logic       spif_q, wcol_q, rd_spsr_q;
  logic [2:0] bit_cnt_q;
  logic [1:0] state_q;
  logic [2:0] sck_q, ss_q;
  logic [1:0] mosi_q;

  logic en, dord, cpol;
  logic sck_rise, sck_fall, sample, shift_e;
  logic ss_sync, ss_fall, mosi_sync, abort, active;
  logic sel_spcr, sel_spsr, sel_spdr, wr_spdr;
  logic spif_set, wcol_set, st_clr;
  logic [7:0] rx_next;

  assign en   = spcr_q[6];
  assign dord = spcr_q[5];
  assign cpol = spcr_q[3];

  assign sck_rise  = sck_q[1] & ~sck_q[2];
  assign sck_fall  = ~sck_q[1] & sck_q[2];
  assign sample    = cpol ? sck_fall : sck_rise;
  assign shift_e   = cpol ? sck_rise : sck_fall;
  assign ss_sync   = ss_q[1];
  assign ss_fall   = ~ss_q[1] & ss_q[2];
  assign mosi_sync = mosi_q[1];

  assign active = (state_q != S_IDLE);
  assign abort  = active & (~en | ss_sync);
  assign rx_next = dord ? {mosi_sync, rx_shift_q[7:1]}
                        : {rx_shift_q[6:0], mosi_sync};

  assign sel_spcr = (addr == SPCR_ADDR);
  assign sel_spsr = (addr == SPSR_ADDR);
  assign sel_spdr = (addr == SPDR_ADDR);
  assign wr_spdr  = wr & sel_spdr;

  assign spif_set = active & ~abort & sample & (bit_cnt_q == 3'd7);
  assign wcol_set = wr_spdr & (state_q == S_SHIFT);
  assign st_clr   = int_rst | (rd_spsr_q & ~rd);

  assign int_o      = spcr_q[7] & spif_q;
  assign io_connect = spcr_q[6];
  assign miso_oe    = en & ~ss_sync;
  assign miso       = miso_oe ? (dord ? tx_shift_q[0] : tx_shift_q[7])
                              : 1'b1;

  // Read mux; silent when not reading or address is unmapped
  always_comb begin
    bus_out = 8'h00;
    if (rd) begin
      if (sel_spcr)      bus_out = spcr_q;
      else if (sel_spsr) bus_out = {spif_q, wcol_q, 6'b0};
      else if (sel_spdr) bus_out = spdr_rx_q;
    end
  end

  // Pin synchronizers; third sck/ss stage feeds edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_q  <= 3'b000;
      ss_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sck_q  <= {sck_q[1:0], sck};
      ss_q   <= {ss_q[1:0], ss_n};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  // Control register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) spcr_q <= 8'h00;
    else if (wr & sel_spcr) spcr_q <= bus_in;
  end

  // Status flags; a new completion beats a simultaneous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spif_q    <= 1'b0;
      wcol_q    <= 1'b0;
      rd_spsr_q <= 1'b0;
    end else begin
      spif_q    <= spif_set | (spif_q & ~st_clr);
      wcol_q    <= wcol_set | (wcol_q & ~st_clr);
      rd_spsr_q <= rd & sel_spsr;
    end
  end

  // Transfer FSM with tx/rx shifters and data registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      tx_buf_q   <= 8'h00;
      tx_shift_q <= 8'h00;
      rx_shift_q <= 8'hFF;
      spdr_rx_q  <= 8'h00;
    end else begin
      if (wr_spdr && (state_q == S_IDLE ||
          (state_q == S_ARMED && bit_cnt_q == 3'd0))) begin
        tx_buf_q <= bus_in;
        if (state_q == S_ARMED) tx_shift_q <= bus_in;
      end
      case (state_q)
        S_IDLE: begin
          if (en && ss_fall) begin
            state_q    <= S_ARMED;
            tx_shift_q <= tx_buf_q;
            bit_cnt_q  <= 3'd0;
          end
        end
        default: begin
          if (abort) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 3'd0;
          end else if (sample) begin
            rx_shift_q <= rx_next;
            if (bit_cnt_q == 3'd7) begin
              spdr_rx_q  <= rx_next;
              bit_cnt_q  <= 3'd0;
              tx_shift_q <= tx_buf_q;
              state_q    <= S_ARMED;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              state_q   <= S_SHIFT;
            end
          end else if (shift_e && state_q == S_SHIFT) begin
            tx_shift_q <= dord ? {1'b0, tx_shift_q[7:1]}
                               : {tx_shift_q[6:0], 1'b0};
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atmega_spi_s.sv
// Directed bench for atmega_spi_s.
// Stimulus queues expectations; a negedge monitor pops and compares.
module tb_atmega_spi_s;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] addr;
  logic       wr, rd;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       irq;
  logic       int_rst;
  logic       io_connect;
  logic       sck, ss_n, mosi;
  logic       miso, miso_oe;

  localparam logic [5:0] A_SPCR = 6'd0;
  localparam logic [5:0] A_SPSR = 6'd1;
  localparam logic [5:0] A_SPDR = 6'd2;

  atmega_spi_s dut (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .rd(rd),
    .bus_in(bus_in), .bus_out(bus_out), .int_o(irq),
    .int_rst(int_rst), .io_connect(io_connect),
    .sck(sck), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] exp;
    int         sel;
  } exp_t;

  exp_t sb[$];
  logic obs_req = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t cur;
  logic [7:0] act;

  always @(negedge clk) begin
    if (obs_req) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL scoreboard: observation with no expectation");
      end else begin
        cur = sb.pop_front();
        case (cur.sel)
          0:       act = bus_out;
          1:       act = {7'b0, miso};
          2:       act = {7'b0, irq};
          3:       act = {7'b0, io_connect};
          default: act = {7'b0, miso_oe};
        endcase
        if (act !== cur.exp) begin
          failures++;
          $display("FAIL %s: got %02h expected %02h",
                   cur.name, act, cur.exp);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] ex,
                     input int sel);
    sb.push_back('{nm, ex, sel});
    obs_req = 1'b1;
    wait_clk(1);
    obs_req = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [5:0] a,
                        input logic [7:0] ex);
    addr = a;
    rd = 1'b1;
    chk(nm, ex, 0);
    rd = 1'b0;
    addr = 6'd0;
    wait_clk(1);
  endtask

  task automatic bus_wr(input logic [5:0] a, input logic [7:0] d);
    addr = a;
    bus_in = d;
    wr = 1'b1;
    wait_clk(1);
    wr = 1'b0;
    addr = 6'd0;
  endtask

  // Master drives bits first..last in wire order, checking miso
  task automatic send_bits(input logic [7:0] tx_m,
                           input logic [7:0] miso_exp,
                           input logic cpol, input logic dord,
                           input int first, input int last);
    int idx;
    for (int i = first; i <= last; i++) begin
      idx = dord ? i : 7 - i;
      mosi = tx_m[idx];
      wait_clk(4);
      chk($sformatf("miso_bit%0d", i), {7'b0, miso_exp[idx]}, 1);
      sck = ~cpol;
      wait_clk(8);
      sck = cpol;
      wait_clk(4);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; addr = 6'd0; wr = 1'b0; rd = 1'b0;
    bus_in = 8'h00; int_rst = 1'b0;
    sck = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    wait_clk(3);
    rd_chk("rst_spcr", A_SPCR, 8'h00);
    rd_chk("rst_spsr", A_SPSR, 8'h00);
    rd_chk("rst_spdr", A_SPDR, 8'h00);
    chk("rst_miso", 8'h01, 1);
    chk("rst_int", 8'h00, 2);
    chk("rst_ioc", 8'h00, 3);
    chk("rst_oe", 8'h00, 4);
    rst = 1'b1;
    wait_clk(3);

    // mode 0, MSB first, 0xA5 out, 0x3C in
    bus_wr(A_SPCR, 8'hC0);
    chk("a_ioc", 8'h01, 3);
    bus_wr(A_SPDR, 8'hA5);
    chk("a_oe_idle", 8'h00, 4);
    ss_n = 1'b0;
    wait_clk(8);
    chk("a_oe_sel", 8'h01, 4);
    send_bits(8'h3C, 8'hA5, 1'b0, 1'b0, 0, 7);
    wait_clk(6);
    chk("a_int", 8'h01, 2);
    rd_chk("a_spsr", A_SPSR, 8'h80);
    rd_chk("a_spdr", A_SPDR, 8'h3C);
    rd_chk("a_spsr_clr", A_SPSR, 8'h00);
    chk("a_int_clr", 8'h00, 2);
    ss_n = 1'b1;
    wait_clk(6);

    // mode 2, LSB first, 0x01 out, 0x80 in
    sck = 1'b1;
    wait_clk(6);
    bus_wr(A_SPCR, 8'h68);
    bus_wr(A_SPDR, 8'h01);
    ss_n = 1'b0;
    wait_clk(8);
    send_bits(8'h80, 8'h01, 1'b1, 1'b1, 0, 7);
    wait_clk(6);
    chk("b_int_off", 8'h00, 2);
    rd_chk("b_spdr", A_SPDR, 8'h80);
    rd_chk("b_spsr", A_SPSR, 8'h80);
    ss_n = 1'b1;
    wait_clk(6);
    sck = 1'b0;
    wait_clk(6);

    // write collision after 3rd sample edge
    bus_wr(A_SPCR, 8'hC0);
    bus_wr(A_SPDR, 8'h96);
    ss_n = 1'b0;
    wait_clk(8);
    send_bits(8'h5A, 8'h96, 1'b0, 1'b0, 0, 2);
    bus_wr(A_SPDR, 8'h55);
    send_bits(8'h5A, 8'h96, 1'b0, 1'b0, 3, 7);
    wait_clk(6);
    chk("c_int", 8'h01, 2);
    rd_chk("c_spsr_wcol", A_SPSR, 8'hC0);
    rd_chk("c_spsr_clr", A_SPSR, 8'h00);
    rd_chk("c_spdr", A_SPDR, 8'h5A);
    ss_n = 1'b1;
    wait_clk(6);

    // abort after 5 bits, then full byte; tx buffer still 0x96
    ss_n = 1'b0;
    wait_clk(8);
    send_bits(8'hFF, 8'h96, 1'b0, 1'b0, 0, 4);
    ss_n = 1'b1;
    wait_clk(8);
    rd_chk("d_spsr_abort", A_SPSR, 8'h00);
    rd_chk("d_spdr_keep", A_SPDR, 8'h5A);
    ss_n = 1'b0;
    wait_clk(8);
    send_bits(8'hC3, 8'h96, 1'b0, 1'b0, 0, 7);
    wait_clk(6);
    rd_chk("d_spdr", A_SPDR, 8'hC3);
    rd_chk("d_spsr", A_SPSR, 8'h80);
    ss_n = 1'b1;
    wait_clk(6);

    // back-to-back bytes without clearing SPIF
    bus_wr(A_SPDR, 8'h3C);
    ss_n = 1'b0;
    wait_clk(8);
    send_bits(8'h11, 8'h3C, 1'b0, 1'b0, 0, 7);
    send_bits(8'h22, 8'h3C, 1'b0, 1'b0, 0, 7);
    wait_clk(6);
    chk("e_int", 8'h01, 2);
    rd_chk("e_spdr", A_SPDR, 8'h22);
    rd_chk("e_spsr", A_SPSR, 8'h80);
    ss_n = 1'b1;
    wait_clk(6);

    // reset mid-byte, then a normal byte
    ss_n = 1'b0;
    wait_clk(8);
    chk("f_ioc_pre", 8'h01, 3);
    send_bits(8'hF0, 8'h3C, 1'b0, 1'b0, 0, 3);
    rst = 1'b0;
    rd_chk("f_rst_spcr", A_SPCR, 8'h00);
    chk("f_rst_miso", 8'h01, 1);
    chk("f_rst_oe", 8'h00, 4);
    chk("f_rst_int", 8'h00, 2);
    chk("f_rst_ioc", 8'h00, 3);
    rd_chk("f_rst_spsr", A_SPSR, 8'h00);
    rd_chk("f_rst_spdr", A_SPDR, 8'h00);
    rst = 1'b1;
    ss_n = 1'b1;
    wait_clk(6);
    bus_wr(A_SPCR, 8'hC0);
    bus_wr(A_SPDR, 8'hE7);
    ss_n = 1'b0;
    wait_clk(8);
    send_bits(8'h81, 8'hE7, 1'b0, 1'b0, 0, 7);
    wait_clk(6);
    chk("f_int", 8'h01, 2);
    rd_chk("f_spdr", A_SPDR, 8'h81);
    rd_chk("f_spsr", A_SPSR, 8'h80);
    ss_n = 1'b1;
    wait_clk(4);

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d left expected 0",
               sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
